uart_coeff_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_coeff_rx_if.sv | 37 +++
 rtl/uart_rx_core.sv | 156 +++++++++++++++
 rtl/uart_coeff_rx.sv | 111 +++++++++++
 tb/tb_uart_coeff_rx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART coefficient receiver and the Newton solver.
//   rx_state_t           : receive FSM state encoding
//   CLKS_PER_BIT_DEFAULT : 100 MHz / 115200 baud
//   COEF_W               : coefficient width, shared with the solver
//   nibble_fits()        : byte is a sign-extended 4-bit value
// Optional feature macro: UART_PARITY_EN (PARITY state is only reachable then).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 868;
    localparam int COEF_W               = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_t;

    // A byte carries a legal coefficient only if its upper nibble merely
    // repeats the sign bit of the lower nibble.
    function automatic logic nibble_fits(input logic [7:0] b);
        return b[7:4] == {4{b[3]}};
    endfunction

endpackage

// File: rtl/uart_coeff_rx_if.sv
// -----------------------------------------------------------------------------
// uart_coeff_rx_if
// Coefficient output bundle from the UART receiver to the solver.
//   DataIn     : signed coefficient, holds until the next accepted byte
//   input_en   : one-cycle strobe, DataIn is new
//   word_idx   : index of the next word expected (0=a,1=b,2=c,3=x0)
//   set_done   : one-cycle pulse with the input_en of the last word of a set
//   frame_err  : one-cycle pulse, stop bit sampled low
//   range_err  : one-cycle pulse, upper nibble not a sign extension
//   parity_err : one-cycle pulse, parity mismatch (0 without UART_PARITY_EN)
//   state      : receive FSM state, debug visibility only
// Handshake: there is no back-pressure. input_en is a pure valid strobe; the
// consumer must take DataIn in the cycle input_en is high.
// -----------------------------------------------------------------------------
interface uart_coeff_rx_if;
    import uart_pkg::*;

    logic signed [COEF_W-1:0] DataIn;
    logic                     input_en;
    logic [1:0]               word_idx;
    logic                     set_done;
    logic                     frame_err;
    logic                     range_err;
    logic                     parity_err;
    rx_state_t                state;

    modport master (
        output DataIn, input_en, word_idx, set_done,
               frame_err, range_err, parity_err, state
    );

    modport slave (
        input  DataIn, input_en, word_idx, set_done,
               frame_err, range_err, parity_err, state
    );

endinterface

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Serial front end: 2-FF synchroniser, bit-timing counter, receive FSM and
// data shift register. Frames are 8N1, or 8E1 when UART_PARITY_EN is defined.
// Ports:
//   clk, reset    : system clock, asynchronous active-high reset
//   i_rx          : raw serial input, idle high, asynchronous to clk
//   o_byte        : received data byte (LSB received first)
//   o_byte_valid  : high in the stop-bit sample cycle; o_byte, o_stop_ok and
//                   o_parity_ok are meaningful in that cycle
//   o_stop_ok     : stop bit is high
//   o_parity_ok   : even parity matches (constant 1 without UART_PARITY_EN)
//   o_state       : current FSM state (debug)
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_stop_ok,
    output logic       o_parity_ok,
    output rx_state_t  o_state
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // Synchroniser resets to the idle level so releasing reset cannot look
    // like a falling start edge.
    logic             r_rx_meta;
    logic             r_rx_sync;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    // Cleared when a frame ends with the line low (break or framing error);
    // a new start is only armed once the line has been seen high again.
    logic             r_armed;
`ifdef UART_PARITY_EN
    logic             r_par;
`endif

    logic w_rxs;
    logic w_bit_end;

    assign w_rxs     = r_rx_sync;
    assign w_bit_end = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_armed   <= 1'b1;
`ifdef UART_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!r_armed) begin
                        if (w_rxs) begin
                            r_armed <= 1'b1;
                        end
                    end else if (!w_rxs) begin
                        r_state <= START;
                    end
                end

                START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        // Line back high at mid-start: treat as a glitch.
                        r_state   <= w_rxs ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef UART_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_par   <= w_rxs;
                        r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_armed <= w_rxs;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The strobe marks the stop-sample cycle itself, so the top level's
    // registered result pulses land in the DONE cycle, one cycle later.
    assign o_byte       = r_shift;
    assign o_byte_valid = (r_state == STOP) && w_bit_end;
    assign o_stop_ok    = w_rxs;
`ifdef UART_PARITY_EN
    assign o_parity_ok  = (r_par == ^r_shift);
`else
    assign o_parity_ok  = 1'b1;
`endif
    assign o_state      = r_state;

endmodule

// File: rtl/uart_coeff_rx.sv
// -----------------------------------------------------------------------------
// uart_coeff_rx
// Upstream stage of the Newton solver: receives UART bytes and forwards each
// legal one as a signed 4-bit coefficient in the order a, b, c, x0.
// Optional feature macro: UART_PARITY_EN (8E1 frames with parity checking;
// without it frames are 8N1 and parity_err stays 0).
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   rx     : serial input, idle high, asynchronous to clk
//   flush  : synchronous, clears the word counter on the next edge
//   o_coef : coefficient bundle (uart_coeff_rx_if.master)
// Error priority per byte is frame > parity > range; exactly one pulse is
// produced per received byte, and error bytes leave DataIn/word_idx alone.
// -----------------------------------------------------------------------------
module uart_coeff_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEFAULT,
    parameter int WORDS_PER_SET = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic               flush,
    uart_coeff_rx_if.master    o_coef
);

    localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_SET - 1);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_stop_ok;
    logic       w_parity_ok;
    rx_state_t  w_state;

    logic [COEF_W-1:0] r_data;
    logic              r_input_en;
    logic [1:0]        r_word_idx;
    logic              r_set_done;
    logic              r_frame_err;
    logic              r_range_err;
    logic              r_parity_err;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .i_rx         (rx),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_stop_ok    (w_stop_ok),
        .o_parity_ok  (w_parity_ok),
        .o_state      (w_state)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data       <= '0;
            r_input_en   <= 1'b0;
            r_word_idx   <= '0;
            r_set_done   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_range_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_input_en   <= 1'b0;
            r_set_done   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_range_err  <= 1'b0;
            r_parity_err <= 1'b0;

            if (w_byte_valid) begin
                if (!w_stop_ok) begin
                    r_frame_err <= 1'b1;
                end else if (!w_parity_ok) begin
                    // w_parity_ok is constant 1 in 8N1 builds, so this
                    // branch and r_parity_err fold away there.
                    r_parity_err <= 1'b1;
                end else if (!nibble_fits(w_byte)) begin
                    r_range_err <= 1'b1;
                end else begin
                    r_data     <= w_byte[COEF_W-1:0];
                    r_input_en <= 1'b1;
                    if (r_word_idx == LAST_WORD) begin
                        r_word_idx <= '0;
                        r_set_done <= !flush;
                    end else begin
                        r_word_idx <= r_word_idx + 2'd1;
                    end
                end
            end

            // flush overrides any increment made above in the same cycle.
            if (flush) begin
                r_word_idx <= '0;
            end
        end
    end

    assign o_coef.DataIn     = r_data;
    assign o_coef.input_en   = r_input_en;
    assign o_coef.word_idx   = r_word_idx;
    assign o_coef.set_done   = r_set_done;
    assign o_coef.frame_err  = r_frame_err;
    assign o_coef.range_err  = r_range_err;
    assign o_coef.parity_err = r_parity_err;
    assign o_coef.state      = w_state;

endmodule

// File: tb/tb_uart_coeff_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_coeff_rx
// Drives UART frames at CLKS_PER_BIT=16 and checks every result pulse against
// an expected-event queue filled when each frame is driven. Each event holds
// the pulse kind, DataIn, word_idx, set_done and the cycle it must appear in.
// -----------------------------------------------------------------------------
module tb_uart_coeff_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Edges from the negedge driving the start bit to the stop-sample edge:
    // 2 synchroniser + half bit + 8 data (+ parity) + stop bit.
    localparam int STOP_EDGE = 2 + CPB / 2 + CPB * (9 + PAR_BITS);

    localparam logic [2:0] K_ACC   = 3'd1;
    localparam logic [2:0] K_FRAME = 3'd2;
    localparam logic [2:0] K_RANGE = 3'd3;
    localparam logic [2:0] K_PAR   = 3'd4;
    localparam int         EW      = 42;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic flush;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_coeff_rx_if u_if ();

    uart_coeff_rx #(
        .CLKS_PER_BIT  (CPB),
        .WORDS_PER_SET (4)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .flush  (flush),
        .o_coef (u_if)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [1:0]    m_w    = 2'd0;
    logic [3:0]    m_data = 4'd0;
    int            flush_tgt = -1;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // flush is a one-cycle pulse timed to cover a chosen stop-sample edge.
    initial begin
        flush = 1'b0;
        forever begin
            @(negedge clk);
            flush = (cyc == flush_tgt);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val = 1'b1,
                             input logic par_flip = 1'b0, input logic do_flush = 1'b0);
        int               n;
        logic [2:0]       k;
        logic             sd;
        logic signed [7:0] sb;
        n  = cyc;
        sb = b;
        sd = 1'b0;
        if (!stop_val)                       k = K_FRAME;
        else if (PAR_BITS == 1 && par_flip)  k = K_PAR;
        else if (sb < -8 || sb > 7)          k = K_RANGE;
        else begin
            k      = K_ACC;
            m_data = b[3:0];
            if (do_flush) m_w = 2'd0;
            else if (m_w == 2'd3) begin
                m_w = 2'd0;
                sd  = 1'b1;
            end else m_w = m_w + 2'd1;
        end
        exp_q.push_back({k, m_data, m_w, sd, 32'(n + 1 + STOP_EDGE)});
        if (do_flush) flush_tgt = n + STOP_EDGE;

        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_val;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic [3:0]    mon_pulses;
    logic [2:0]    mon_kind;
    logic [EW-1:0] mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            mon_pulses = {u_if.input_en, u_if.frame_err, u_if.range_err, u_if.parity_err};
            if (mon_pulses != 4'd0) begin
                mon_kind = u_if.input_en  ? K_ACC   :
                           u_if.frame_err ? K_FRAME :
                           u_if.range_err ? K_RANGE : K_PAR;
                check_val("one_pulse", 64'($countones(mon_pulses)), 64'd1);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_pulse", 64'(mon_pulses), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("kind",     64'(mon_kind),                 64'(mon_e[41:39]));
                    check_val("DataIn",   64'($unsigned(u_if.DataIn)),   64'(mon_e[38:35]));
                    check_val("word_idx", 64'(u_if.word_idx),            64'(mon_e[34:33]));
                    check_val("set_done", 64'(u_if.set_done),            64'(mon_e[32]));
                    check_val("latency",  64'(cyc),                      64'(mon_e[31:0]));
                end
            end else if (u_if.set_done) begin
                check_val("stray_set_done", 64'(u_if.set_done), 64'd0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_DataIn",   64'($unsigned(u_if.DataIn)), 64'd0);
        check_val("rst_input_en", 64'(u_if.input_en),  64'd0);
        check_val("rst_word_idx", 64'(u_if.word_idx),  64'd0);
        check_val("rst_set_done", 64'(u_if.set_done),  64'd0);
        check_val("rst_errs",     64'({u_if.frame_err, u_if.range_err, u_if.parity_err}), 64'd0);
        check_val("rst_state",    64'(u_if.state),     64'(IDLE));
        reset = 1'b0;
        idle(2 * CPB);

        // Four legal coefficients back to back: one full set.
        send_byte(8'h03);
        send_byte(8'hFE);
        send_byte(8'h01);
        send_byte(8'h00);
        idle(CPB);

        // Out-of-range byte dropped, then the most negative legal value.
        send_byte(8'h25);
        send_byte(8'hF8);
        idle(CPB);

        // Framing error, then a break of 40 bit times, then recovery.
        send_byte(8'h05, 1'b0);
        idle(2 * CPB);
        exp_q.push_back({K_FRAME, m_data, m_w, 1'b0, 32'(cyc + 1 + STOP_EDGE)});
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        idle(2 * CPB);
        send_byte(8'h02);
        idle(CPB);

        // Short low glitch from idle: nothing may come out.
        rx = 1'b0;
        repeat (6) @(negedge clk);
        idle(2 * CPB);
        check_val("glitch_idle", 64'(u_if.state), 64'(IDLE));

        // Reset in the middle of the data bits of 0x07.
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        repeat (CPB / 2) @(negedge clk);
        check_val("mid_frame_state", 64'(u_if.state), 64'(DATA));
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_val("midrst_state",    64'(u_if.state),    64'(IDLE));
        check_val("midrst_word_idx", 64'(u_if.word_idx), 64'd0);
        check_val("midrst_DataIn",   64'($unsigned(u_if.DataIn)), 64'd0);
        reset  = 1'b0;
        m_w    = 2'd0;
        m_data = 4'd0;
        idle(2 * CPB);
        send_byte(8'h01);

        // flush during the third accept of a set: word_idx to 0, no set_done.
        send_byte(8'h06);
        send_byte(8'h07, 1'b1, 1'b0, 1'b1);
        send_byte(8'hFF);
        idle(CPB);

`ifdef UART_PARITY_EN
        send_byte(8'h03);
        send_byte(8'h03, 1'b1, 1'b1);
        idle(CPB);
`endif

        idle(4 * CPB);
        check_val("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
